// File: rtl/mul32_seq_ctrl_if.sv
// Request/response and Dadda-multiplier signals of the sequential RV32M multiply controller.
// The slave side is the controller. The master side is the ALU operand mux plus the Dadda array.
interface mul32_seq_ctrl_if #(
  parameter int HALF_W = 16
);
  logic                  start;
  logic [1:0]            op;
  logic [2*HALF_W-1:0]   rs1;
  logic [2*HALF_W-1:0]   rs2;
  logic                  busy;
  logic                  done;
  logic [2*HALF_W-1:0]   result;
  logic [HALF_W-1:0]     dadda_a;
  logic [HALF_W-1:0]     dadda_b;
  logic [2*HALF_W-1:0]   dadda_y;

  modport master (
    output start, op, rs1, rs2, dadda_y,
    input  busy, done, result, dadda_a, dadda_b
  );

  modport slave (
    input  start, op, rs1, rs2, dadda_y,
    output busy, done, result, dadda_a, dadda_b
  );
endinterface

// File: rtl/mul32_seq_ctrl.sv
// Multi-cycle RV32M MUL/MULH/MULHSU/MULHU sequencer around an external 16x16 unsigned Dadda array.
// The operand magnitudes are fed in four half-word pairs. The partial products are summed, then sign-fixed.
module mul32_seq_ctrl #(
  parameter int HALF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul32_seq_ctrl_if.slave      bus
);
  localparam int W = 2 * HALF_W;
  localparam int P = 2 * W;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PP0,
    S_PP1,
    S_PP2,
    S_PP3,
    S_FIX
  } state_e;

  state_e            state, state_nxt;
  op_e               op_q;
  logic [W-1:0]      a_q, b_q;
  logic              neg_q;
  logic [P-1:0]      acc;
  logic              busy_q, done_q;
  logic [W-1:0]      result_q;

  op_e               op_in;
  logic              rs1_neg, rs2_neg;
  logic [W-1:0]      rs1_mag, rs2_mag;
  logic [HALF_W-1:0] dadda_a_c, dadda_b_c;
  logic [P-1:0]      pp_shifted;
  logic [P-1:0]      prod;

  // Only the operands that the op treats as signed are folded to a magnitude.
  // The magnitude of 0x80000000 is 0x80000000 itself.
  assign op_in   = op_e'(bus.op);
  assign rs1_neg = ((op_in == OP_MULH) || (op_in == OP_MULHSU)) && bus.rs1[W-1];
  assign rs2_neg = (op_in == OP_MULH) && bus.rs2[W-1];
  assign rs1_mag = rs1_neg ? -bus.rs1 : bus.rs1;
  assign rs2_mag = rs2_neg ? -bus.rs2 : bus.rs2;
  assign prod    = neg_q ? -acc : acc;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    dadda_a_c  = '0;
    dadda_b_c  = '0;
    pp_shifted = '0;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_PP0;
      S_PP0: begin
        dadda_a_c  = a_q[HALF_W-1:0];
        dadda_b_c  = b_q[HALF_W-1:0];
        pp_shifted = {{W{1'b0}}, bus.dadda_y};
        state_nxt  = S_PP1;
      end
      S_PP1: begin
        dadda_a_c  = a_q[HALF_W-1:0];
        dadda_b_c  = b_q[W-1:HALF_W];
        pp_shifted = {{W{1'b0}}, bus.dadda_y} << HALF_W;
        state_nxt  = S_PP2;
      end
      S_PP2: begin
        dadda_a_c  = a_q[W-1:HALF_W];
        dadda_b_c  = b_q[HALF_W-1:0];
        pp_shifted = {{W{1'b0}}, bus.dadda_y} << HALF_W;
        state_nxt  = S_PP3;
      end
      S_PP3: begin
        dadda_a_c  = a_q[W-1:HALF_W];
        dadda_b_c  = b_q[W-1:HALF_W];
        pp_shifted = {bus.dadda_y, {W{1'b0}}};
        state_nxt  = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand and accumulator registers are reset as well. A reset in mid-operation then leaves no stale partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      acc      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: if (bus.start) begin
          op_q  <= op_in;
          a_q   <= rs1_mag;
          b_q   <= rs2_mag;
          neg_q <= rs1_neg ^ rs2_neg;
          acc   <= '0;
        end
        S_PP0, S_PP1, S_PP2, S_PP3: acc <= acc + pp_shifted;
        S_FIX: begin
          result_q <= (op_q == OP_MUL) ? prod[W-1:0] : prod[P-1:W];
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.dadda_a = dadda_a_c;
  assign bus.dadda_b = dadda_b_c;
endmodule
